// File: rtl/soc_button_pio.sv
// Avalon-MM PIO input slave: synchronise, debounce and edge-capture WIDTH button inputs with a masked level irq.
// Build option: define SOC_BUTTON_PIO_INVERT_EN to invert in_port ahead of the synchroniser (active-low buttons).
module soc_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] pin_level;
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [CNT_W-1:0] stable_cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             unused_wdata;

`ifdef SOC_BUTTON_PIO_INVERT_EN
  assign pin_level = ~in_port;
`else
  assign pin_level = in_port;
`endif

  assign wr_en        = chipselect & ~write_n;
  assign clear_bits   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      0:       edge_hit = debounced & ~debounced_d;
      1:       edge_hit = ~debounced & debounced_d;
      default: edge_hit = debounced ^ debounced_d;
    endcase
  end

  always_comb begin
    read_mux = '0;
    if (chipselect) begin
      case (address)
        2'd0:    read_mux = 32'(debounced);
        2'd1:    read_mux = 32'(irq_mask);
        2'd3:    read_mux = 32'(edge_capture);
        default: read_mux = '0;
      endcase
    end
  end

  // A bit only moves once the synchronised level has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1     <= '0;
      sync_q2     <= '0;
      debounced   <= '0;
      debounced_d <= '0;
      for (int i = 0; i < WIDTH; i++) stable_cnt[i] <= '0;
    end else begin
      sync_q1     <= pin_level;
      sync_q2     <= sync_q1;
      debounced_d <= debounced;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q2[i] != debounced[i]) begin
          if (stable_cnt[i] == CNT_LAST) begin
            debounced[i]  <= sync_q2[i];
            stable_cnt[i] <= '0;
          end else begin
            stable_cnt[i] <= stable_cnt[i] + CNT_W'(1);
          end
        end else begin
          stable_cnt[i] <= '0;
        end
      end
    end
  end

  // A fresh edge outranks a same-cycle write-1-to-clear so no press is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      if (wr_en && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= read_mux;
    end
  end

endmodule

// File: tb/tb_soc_button_pio.sv
// Scoreboard bench for soc_button_pio: driver queues expected reads/irq levels, a negedge monitor compares.
module tb_soc_button_pio;

`ifdef SOC_BUTTON_PIO_INVERT_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata2;
  logic [3:0]  in_port = 4'hF, in_port2 = 4'hF;
  logic        irq, irq2;
  logic [3:0]  prs = '0, prs2 = '0;

  always #5 clk = ~clk;

  soc_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_MODE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));

  soc_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_MODE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2));

  typedef struct { bit sel; logic [31:0] exp; string nm; } rd_t;
  typedef struct { logic exp; string nm; } irq_t;
  rd_t  rd_q[$];
  irq_t irq_q[$];
  rd_t  re;
  irq_t ie;
  int   n_vec = 0, n_err = 0;
  logic rd_valid = 1'b0, irq_probe = 1'b0, drain_req = 1'b0, drained = 1'b0;
  logic [31:0] got;

  always @(posedge clk) rd_valid <= chipselect && write_n;

  always @(negedge clk) begin
    if (rd_valid) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read got %h required none", readdata);
      end else begin
        re  = rd_q.pop_front();
        got = re.sel ? readdata2 : readdata;
        if (got !== re.exp) begin
          n_err++;
          $display("FAIL %s got %h required %h", re.nm, got, re.exp);
        end
      end
    end
    if (irq_probe) begin
      n_vec++;
      if (irq_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_irq_probe got %b required none", irq);
      end else begin
        ie = irq_q.pop_front();
        if (irq !== ie.exp) begin
          n_err++;
          $display("FAIL %s irq got %b required %b", ie.nm, irq, ie.exp);
        end
      end
    end
    if (drain_req && !drained) begin
      drained = 1'b1;
      n_vec++;
      if (rd_q.size() != 0 || irq_q.size() != 0) begin
        n_err++;
        $display("FAIL drain pending got %0d required 0", rd_q.size() + irq_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    irq_probe = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive();
    in_port  = prs ^ INV;
    in_port2 = prs2 ^ INV;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string nm);
    rd_t e;
    e.sel = sel; e.exp = exp; e.nm = nm;
    rd_q.push_back(e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    irq_t e;
    e.exp = exp; e.nm = nm;
    irq_q.push_back(e);
    irq_probe = 1'b1;
  endtask

  initial begin
    // reset with all raw pins high
    ticks(2);
    chk_irq(1'b0, "rst_irq");
    rd(0, 2'd0, 32'h0, "rst_data");
    reset_n = 1'b1;
    rd(0, 2'd3, 32'h0, "post_rst_cap");
    rd(0, 2'd0, 32'h0, "post_rst_data");
    prs = '0; prs2 = '0; drive();
    ticks(15);

    // short glitch is filtered, held level appears 10 edges after the pin change
    prs[0] = 1'b1; drive();
    for (int k = 0; k < 5; k++) rd(0, 2'd0, 32'h0, "glitch_data");
    prs[0] = 1'b0; drive();
    for (int k = 0; k < 12; k++) rd(0, 2'd0, 32'h0, "glitch_after");
    prs[0] = 1'b1; drive();
    for (int k = 0; k < 12; k++) rd(0, 2'd0, (k >= 10) ? 32'h1 : 32'h0, "deb_latency");
    rd(0, 2'd3, 32'h1, "rise_cap");
    wr(2'd3, 32'hF);
    rd(0, 2'd3, 32'h0, "w1c_clear");
    prs[0] = 1'b0; drive();
    ticks(13);
    rd(0, 2'd3, 32'h0, "mode0_no_fall");

    // masked edge raises irq, W1C drops it one cycle after the clear
    wr(2'd1, 32'h2);
    prs[1] = 1'b1; drive();
    ticks(13);
    chk_irq(1'b1, "irq_on_edge");
    rd(0, 2'd3, 32'h2, "cap_bit1");
    wr(2'd3, 32'h2);
    chk_irq(1'b1, "irq_clear_lag");
    tick();
    chk_irq(1'b0, "irq_cleared");
    rd(0, 2'd3, 32'h0, "cap_bit1_clr");

    // unmasked capture holds irq low until the mask is opened
    wr(2'd1, 32'h0);
    prs[2] = 1'b1; drive();
    ticks(13);
    chk_irq(1'b0, "irq_masked");
    rd(0, 2'd3, 32'h4, "cap_bit2");
    wr(2'd1, 32'hFFFF_FFF4);
    chk_irq(1'b0, "irq_mask_lag");
    tick();
    chk_irq(1'b1, "irq_mask_open");
    rd(0, 2'd1, 32'h4, "mask_readback");
    rd(0, 2'd2, 32'h0, "reserved_read");
    wr(2'd0, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'h6, "data_ro");

    // W1C in the same cycle as a new rising edge leaves the bit set
    wr(2'd3, 32'hF);
    chk_irq(1'b1, "irq_before_clr");
    prs[0] = 1'b1; drive();
    ticks(10);
    wr(2'd3, 32'h1);
    rd(0, 2'd3, 32'h1, "w1c_collision");
    chk_irq(1'b0, "irq_collision_masked");
    tick();

    // both-edge instance: press and release are each captured
    prs2[3] = 1'b1; drive();
    ticks(13);
    rd(1, 2'd3, 32'h8, "both_press_cap");
    rd(1, 2'd0, 32'h8, "both_press_data");
    wr(2'd3, 32'h8);
    rd(1, 2'd3, 32'h0, "both_cleared");
    prs2[3] = 1'b0; drive();
    ticks(13);
    rd(1, 2'd3, 32'h8, "both_release_cap");
    rd(1, 2'd0, 32'h0, "both_release_data");

    ticks(3);
    drain_req = 1'b1;
    ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soc_button_pio.md
Name: soc_button_pio
Overview: Parametrised Avalon-MM PIO input slave for push-buttons and switches, the successor to the single-bit read-only button port. Takes WIDTH asynchronous inputs, synchronises and debounces them, and latches rising/falling edges into a capture register. Raises a level interrupt to the Nios II CPU through a per-bit mask. Sits on the SoC Avalon bus beside the other PIO peripherals.

Parameters:
WIDTH, 4, number of button/switch input bits (1..32)
DEBOUNCE_CYCLES, 50000, cycles an input must hold stable before the debounced value updates (>=1)
EDGE_MODE, 1, 0 = capture rising edges, 1 = capture falling edges, 2 = capture both edges

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset, sampled on posedge clk
address  input  2  Avalon word address
chipselect  input  1  Avalon slave select
write_n  input  1  Avalon active-low write strobe
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
in_port  input  WIDTH  raw asynchronous button inputs
irq  output  1  level interrupt to CPU

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is synchronous and active-low. All state updates on posedge clk only.
- Reset values: readdata=0, irq=0, irq_mask=0, edge_capture=0, sync stages=0, debounced=0, all debounce counters=0.
- Sync: 2-flop synchroniser per bit. The synchronised value is the input to debounce.
- Debounce, per bit: if sync != debounced, count up; otherwise clear the count. When the count reaches DEBOUNCE_CYCLES-1 while still differing, debounced <= sync and the count clears. A bit must differ for DEBOUNCE_CYCLES consecutive cycles to update. A glitch shorter than that resets the count and produces no change. Counter width is clog2(DEBOUNCE_CYCLES)+1.
- Edge detect: compare debounced to its 1-cycle-delayed copy, select edges per EDGE_MODE, and set the matching edge_capture bit. Bits are sticky.
- Register map (address):
  - 0 data: read = debounced zero-extended. Writes are ignored.
  - 1 irq_mask: read/write, bits [WIDTH-1:0]. Upper write bits are ignored.
  - 2 reserved: reads 0, writes ignored.
  - 3 edge_capture: read returns captures. Write clears every bit whose writedata bit is 1 (write-1-to-clear).
- Write occurs when chipselect=1 and write_n=0.
- Read: readdata is registered every cycle from the address mux, giving 1-cycle read latency (Avalon readLatency=1). Unselected addresses return 0. Bits above WIDTH always read 0.
- Simultaneous new edge and W1C on the same bit: the set wins and the bit stays 1.
- irq is registered: irq <= |(edge_capture & irq_mask), so it asserts the cycle after the capture bit or mask bit becomes 1. It deasserts the cycle after the clear.
- Reset mid-debounce discards the count. No edge is generated by reset itself, because the delayed copy also resets to 0.

Optional Feature:
Macro SOC_BUTTON_PIO_INVERT_EN.
- Defined: in_port is inverted before the synchroniser, for active-low buttons. A pressed button reads 1 in data and is reset-safe: raw high = not pressed.
- Undefined: no inversion, and data reflects the raw pin level after debounce.

Test Plan:
1. Reset: hold reset_n=0 for 3 clk with in_port=4'hF -> readdata=0, irq=0. After release, read addr3 -> 0, because the debounce delay has not elapsed.
2. Debounce, DEBOUNCE_CYCLES=8: pulse in_port[0]=1 for 5 cycles -> data stays 0. Hold for 12 cycles -> data bit0=1 exactly 2+8 cycles after the edge, then 1-cycle read latency.
3. Edge + irq, EDGE_MODE=0: write addr1=4'b0010, press bit1 -> addr3 reads 4'b0010 and irq=1. Write addr3=4'b0010 -> irq=0 the cycle after the capture bit clears.
4. Masked bit: mask=0 and press bit2 -> capture bit2=1, irq stays 0. Then write mask=4'b0100 -> irq=1 one cycle later.
5. Clear/set collision: a W1C on bit0 in the same cycle a new rising edge on bit0 is detected -> bit0 remains 1.
6. EDGE_MODE=2 with SOC_BUTTON_PIO_INVERT_EN defined: drive in_port[3] 1->0->1 (press and release) -> capture bit3 is set on both the press and the release, and data bit3 reads 1 while the pin is low.
